// File: rtl/bytemem_ctrl_if.sv
// Request/response bus of the byte-addressable data memory.
// master: datapath side; slave: memory controller side.
interface bytemem_ctrl_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32
);
  localparam int SZW = $clog2(DATA_BYTES) + 1;
  localparam int DW  = 8 * DATA_BYTES;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [SZW-1:0]        req_size;
  logic                  req_unsigned;
  logic [DW-1:0]         req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bytemem_ctrl.sv
// Byte-addressable data memory with req/rsp port and reset sweep.
// Ports: clk, reset (sync, high), bus (slave), init_done.
module bytemem_ctrl #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int READ_LAT   = 1
) (
  input  logic          clk,
  input  logic          reset,
  bytemem_ctrl_if.slave bus,
  output logic          init_done
);
  localparam int LGB   = $clog2(DATA_BYTES);
  localparam int SZW   = LGB + 1;
  localparam int MAW   = $clog2(DEPTH);
  localparam int WORDS = DEPTH / DATA_BYTES;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(READ_LAT) + 1;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int XW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    CLEAR, IDLE, BUSY, RESP
  } state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [IW-1:0]  sweep;
  logic [CW-1:0]  cnt;
  logic           rdy_q;

  logic           size_bad;
  logic           mis;
  logic           oor;
  logic           err;
  logic           accept;
  logic [SZW-1:0] lg;
  logic [XW-1:0]  nb;
  logic [XW-1:0]  aext;
  logic [MAW-1:0] base;
  logic [DW-1:0]  ld;
  logic           sgn;

  assign bus.req_ready = rdy_q & ~reset;
  assign accept = bus.req_valid & bus.req_ready;
  assign base = bus.req_addr[MAW-1:0];

  always_comb begin
    size_bad = bus.req_size > SZW'(LGB);
    lg   = size_bad ? '0 : bus.req_size;
    nb   = XW'(1) << lg;
    aext = {1'b0, bus.req_addr};
    mis  = |(aext & (nb - XW'(1)));
    // 33-bit sum so addresses near the top cannot wrap into range
    oor  = (aext + nb) > XW'(DEPTH);
    err  = size_bad | mis | oor;
    ld   = '0;
    sgn  = 1'b0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (XW'(k) < nb) begin
        ld[8*k +: 8] = mem[base + MAW'(k)];
        // last lane written is byte n-1, the sign source
        sgn = mem[base + MAW'(k)][7];
      end
    end
    if (!bus.req_unsigned && sgn) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (XW'(k) >= nb)
          ld[8*k +: 8] = 8'hFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      for (int j = 0; j < DATA_BYTES; j++)
        mem[MAW'({sweep, {LGB{1'b0}}}) + MAW'(j)] <= '0;
    end else if (accept && bus.req_we && !err) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (XW'(k) < nb)
          mem[base + MAW'(k)] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      sweep         <= '0;
      cnt           <= '0;
      rdy_q         <= 1'b0;
      init_done     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (sweep == IW'(WORDS - 1)) begin
            state     <= IDLE;
            rdy_q     <= 1'b1;
            init_done <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            rdy_q         <= 1'b0;
            bus.rsp_err   <= err;
            bus.rsp_rdata <= (bus.req_we || err) ? '0 : ld;
            if (!bus.req_we && READ_LAT > 1) begin
              state <= BUSY;
              cnt   <= '0;
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == CW'(READ_LAT - 2)) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            rdy_q         <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_bytemem_ctrl.sv
// Directed bench for bytemem_ctrl.
// Two instances: READ_LAT=1 (a) and READ_LAT=3 (b).
module tb_bytemem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_unsigned = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        done_a;
  logic        done_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bytemem_ctrl_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) ia ();
  bytemem_ctrl_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) ib ();

  assign ia.req_valid    = req_valid & ~sel;
  assign ib.req_valid    = req_valid & sel;
  assign ia.rsp_ready    = rsp_ready & ~sel;
  assign ib.rsp_ready    = rsp_ready & sel;
  assign ia.req_we       = req_we;
  assign ib.req_we       = req_we;
  assign ia.req_addr     = req_addr;
  assign ib.req_addr     = req_addr;
  assign ia.req_size     = req_size;
  assign ib.req_size     = req_size;
  assign ia.req_unsigned = req_unsigned;
  assign ib.req_unsigned = req_unsigned;
  assign ia.req_wdata    = req_wdata;
  assign ib.req_wdata    = req_wdata;

  bytemem_ctrl #(
    .DATA_BYTES(4), .ADDR_WIDTH(32),
    .DEPTH(256), .READ_LAT(1)
  ) ua (
    .clk(clk), .reset(reset),
    .bus(ia.slave), .init_done(done_a)
  );

  bytemem_ctrl #(
    .DATA_BYTES(4), .ADDR_WIDTH(32),
    .DEPTH(256), .READ_LAT(3)
  ) ub (
    .clk(clk), .reset(reset),
    .bus(ib.slave), .init_done(done_b)
  );

  logic        rrdy;
  logic        rv;
  logic        rerr;
  logic        idone;
  logic [31:0] rrd;

  assign rrdy  = sel ? ib.req_ready : ia.req_ready;
  assign rv    = sel ? ib.rsp_valid : ia.rsp_valid;
  assign rerr  = sel ? ib.rsp_err   : ia.rsp_err;
  assign rrd   = sel ? ib.rsp_rdata : ia.rsp_rdata;
  assign idone = sel ? done_b       : done_a;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Starts and ends on a negedge; returns data, error and
  // cycles from the accept edge to rsp_valid seen.
  task automatic do_req(input logic we,
                        input logic [31:0] addr,
                        input logic [2:0] sz,
                        input logic uns,
                        input logic [31:0] wd,
                        input logic early,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat);
    int k;
    rd = '0;
    er = 1'b0;
    lat = -1;
    rsp_ready = early;
    req_we = we;
    req_addr = addr;
    req_size = sz;
    req_unsigned = uns;
    req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!rrdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rrdy) begin
      req_valid = 1'b0;
      timeout("req_ready");
    end else begin
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rv && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      if (!rv) begin
        timeout("rsp_valid");
        lat = -1;
      end else begin
        rd = rrd;
        er = rerr;
        rsp_ready = 1'b1;
        @(negedge clk);
      end
    end
    rsp_ready = 1'b0;
  endtask

  // Counts posedges after reset release until init_done.
  task automatic count_sweep(input string nm);
    int c;
    logic quiet;
    c = 0;
    quiet = 1'b1;
    while (!idone && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      if (rv) quiet = 1'b0;
    end
    check({nm, " sweep cycles"}, 32'(c), 32'd64);
    check({nm, " rsp quiet"}, {31'b0, quiet}, 32'd0 + 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    tab.push_back('{1'b1, 32'h20, 3'd2, 1'b0, 32'h80F17F02, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'h21, 3'd0, 1'b0, 32'h0, 32'h0000007F, 1'b0});
    tab.push_back('{1'b0, 32'h22, 3'd0, 1'b0, 32'h0, 32'hFFFFFFF1, 1'b0});
    tab.push_back('{1'b0, 32'h23, 3'd0, 1'b1, 32'h0, 32'h00000080, 1'b0});
    tab.push_back('{1'b0, 32'h22, 3'd1, 1'b0, 32'h0, 32'hFFFF80F1, 1'b0});
    tab.push_back('{1'b0, 32'h20, 3'd1, 1'b1, 32'h0, 32'h00007F02, 1'b0});
    tab.push_back('{1'b0, 32'h20, 3'd2, 1'b0, 32'h0, 32'h80F17F02, 1'b0});
    tab.push_back('{1'b0, 32'h20, 3'd2, 1'b1, 32'h0, 32'h80F17F02, 1'b0});
    tab.push_back('{1'b1, 32'h40, 3'd2, 1'b0, 32'h11223344, 32'h0, 1'b0});
    tab.push_back('{1'b1, 32'h42, 3'd0, 1'b0, 32'h000000AA, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'h40, 3'd2, 1'b0, 32'h0, 32'h11AA3344, 1'b0});
    tab.push_back('{1'b0, 32'h31, 3'd1, 1'b0, 32'h0, 32'h0, 1'b1});
    tab.push_back('{1'b1, 32'h102, 3'd2, 1'b0, 32'h5555AAAA, 32'h0, 1'b1});
    tab.push_back('{1'b1, 32'hFC, 3'd2, 1'b0, 32'h12345678, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'hFC, 3'd2, 1'b0, 32'h0, 32'h12345678, 1'b0});
    tab.push_back('{1'b0, 32'h00, 3'd3, 1'b0, 32'h0, 32'h0, 1'b1});
    tab.push_back('{1'b1, 32'h00, 3'd3, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1});
    tab.push_back('{1'b1, 32'h0C, 3'd2, 1'b0, 32'h01020304, 32'h0, 1'b0});
    tab.push_back('{1'b1, 32'h0E, 3'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1});
    tab.push_back('{1'b0, 32'h0C, 3'd2, 1'b0, 32'h0, 32'h01020304, 1'b0});
    tab.push_back('{1'b0, 32'h00, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'h100, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1});
    tab.push_back('{1'b0, 32'hFF, 3'd0, 1'b0, 32'h0, 32'h00000012, 1'b0});
    tab.push_back('{1'b0, 32'hFE, 3'd1, 1'b0, 32'h0, 32'h00001234, 1'b0});
    tab.push_back('{1'b0, 32'hFFFFFFFF, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1});
    tab.push_back('{1'b1, 32'h50, 3'd1, 1'b0, 32'hFFFF8001, 32'h0, 1'b0});
    tab.push_back('{1'b0, 32'h50, 3'd2, 1'b0, 32'h0, 32'h00008001, 1'b0});
    tab.push_back('{1'b0, 32'h50, 3'd1, 1'b0, 32'h0, 32'hFFFF8001, 1'b0});
    tab.push_back('{1'b0, 32'h50, 3'd1, 1'b1, 32'h0, 32'h00008001, 1'b0});

    repeat (3) @(negedge clk);
    check("rst req_ready", {31'b0, ia.req_ready}, 32'd0);
    check("rst rsp_valid", {31'b0, ia.rsp_valid}, 32'd0);
    check("rst rsp_rdata", ia.rsp_rdata, 32'd0);
    check("rst rsp_err", {31'b0, ia.rsp_err}, 32'd0);
    check("rst init_done", {31'b0, done_a}, 32'd0);
    check("rst b rsp_valid", {31'b0, ib.rsp_valid}, 32'd0);
    reset = 1'b0;
    count_sweep("first");

    for (int i = 0; i < 64; i++) begin
      do_req(1'b1, 32'(4 * i), 3'd2, 1'b0, 32'hFFFFFFFF,
             1'b0, rd, er, lat);
    end
    do_req(1'b0, 32'h10, 3'd2, 1'b0, '0, 1'b0, rd, er, lat);
    check("fill lw 0x10", rd, 32'hFFFFFFFF);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_sweep("refill");
    do_req(1'b0, 32'h10, 3'd2, 1'b0, '0, 1'b0, rd, er, lat);
    check("swept lw 0x10", rd, 32'h0);
    do_req(1'b0, 32'hFC, 3'd2, 1'b0, '0, 1'b0, rd, er, lat);
    check("swept lw 0xFC", rd, 32'h0);

    foreach (tab[i]) begin
      do_req(tab[i].we, tab[i].addr, tab[i].size, tab[i].uns,
             tab[i].wdata, 1'b0, rd, er, lat);
      check($sformatf("v%0d rdata", i), rd, tab[i].exp_rd);
      check($sformatf("v%0d err", i), {31'b0, er},
            {31'b0, tab[i].exp_err});
      check($sformatf("v%0d lat", i), 32'(lat), 32'd1);
    end

    sel = 1'b1;
    @(negedge clk);
    do_req(1'b1, 32'h60, 3'd2, 1'b0, 32'hCAFEF00D, 1'b0,
           rd, er, lat);
    check("b sw lat", 32'(lat), 32'd1);
    do_req(1'b0, 32'h63, 3'd0, 1'b0, '0, 1'b1, rd, er, lat);
    check("b lb rdata", rd, 32'hFFFFFFCA);
    check("b lb early lat", 32'(lat), 32'd3);
    do_req(1'b0, 32'h61, 3'd1, 1'b0, '0, 1'b0, rd, er, lat);
    check("b err ld err", {31'b0, er}, 32'd1);
    check("b err ld lat", 32'(lat), 32'd3);
    do_req(1'b1, 32'h61, 3'd2, 1'b0, 32'h1, 1'b0, rd, er, lat);
    check("b err st err", {31'b0, er}, 32'd1);
    check("b err st lat", 32'(lat), 32'd1);

    req_we = 1'b0;
    req_addr = 32'h60;
    req_size = 3'd2;
    req_unsigned = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    check("b bp idle ready", {31'b0, rrdy}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rv && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("b bp lat", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("b bp%0d valid", c), {31'b0, rv}, 32'd1);
      check($sformatf("b bp%0d rdata", c), rrd, 32'hCAFEF00D);
      check($sformatf("b bp%0d ready", c), {31'b0, rrdy}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b bp done valid", {31'b0, rv}, 32'd0);
    check("b bp done ready", {31'b0, rrdy}, 32'd1);

    req_we = 1'b0;
    req_addr = 32'h60;
    req_size = 3'd2;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid rst valid", {31'b0, rv}, 32'd0);
    check("mid rst init_done", {31'b0, idone}, 32'd0);
    check("mid rst ready", {31'b0, rrdy}, 32'd0);
    reset = 1'b0;
    count_sweep("mid");
    do_req(1'b0, 32'h60, 3'd2, 1'b0, '0, 1'b0, rd, er, lat);
    check("mid lw rdata", rd, 32'h0);
    check("mid lw lat", 32'(lat), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
